gmii_rx_tag: RTL and testbench
==============================

GMII_RX_TAG -- requirements
Module: gmii_rx_tag

Interface
REQ-001 Parameter MAX_LEN, default 1522, max data bytes (post-SFD, FCS included) accepted per frame.
REQ-002 i_clk  input  1  clock (125 MHz GMII Rx domain).
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_gmii_rx_dv  input  1  GMII receive data valid.
REQ-005 i_gmii_rx_er  input  1  GMII receive error.
REQ-006 iv_gmii_rxd  input  8  GMII receive byte.
REQ-007 o_data_wr  output  1  byte-stream write strobe to the byte-to-134-bit splice stage.
REQ-008 ov_data  output  9  [8] = boundary flag (first or last byte of frame); [7:0] = data byte.
REQ-009 ov_frame_cnt  output  16  frames delivered with a tagged tail.
REQ-010 ov_err_cnt  output  16  frames truncated or dropped (rx_er, oversize, bad preamble).
REQ-011 ov_rx_state  output  2  current FSM state, debug.

Function
REQ-012 FSM states: IDLE=0, PREAMBLE=1, DATA=2, DISCARD=3.
REQ-013 IDLE: rx_dv=1 with rxd=0x55 -> PREAMBLE; rx_dv=1 with rxd=0xD5 -> DATA; rx_dv=1 with any other byte -> DISCARD, err_cnt+1.
REQ-014 PREAMBLE: 0x55 -> stay; 0xD5 -> DATA; other byte -> DISCARD, err_cnt+1; rx_dv=0 -> IDLE, no count.
REQ-015 Preamble and SFD bytes never appear on the output.
REQ-016 DATA: each byte is held in a one-byte hold register; the held byte is emitted only when the next GMII cycle is sampled (next byte or rx_dv=0).
REQ-017 Emitted byte gets ov_data[8]=1 if it is the first data byte of the frame, or if it is emitted because rx_dv fell (last byte); otherwise ov_data[8]=0.
REQ-018 Latency: data byte sampled at edge N drives ov_data with o_data_wr=1 for exactly the cycle after edge N+1.
REQ-019 o_data_wr is 0 and ov_data is 9'h000 in every cycle with no emitted byte.
REQ-020 Frame with exactly 1 data byte: no output, err_cnt+1 (splice stage requires distinct head and tail bytes).
REQ-021 rx_dv falls in DATA with >=2 bytes: last byte emitted with [8]=1, frame_cnt+1, -> IDLE.
REQ-022 rx_er=1 in DATA: if head already emitted, held byte emitted as tail ([8]=1); else held byte dropped; err_cnt+1; -> DISCARD.
REQ-023 Byte count reaching MAX_LEN with a further byte arriving: held byte emitted as tail, err_cnt+1, -> DISCARD; frame_cnt not incremented.
REQ-024 DISCARD: no output; -> IDLE on first cycle with rx_dv=0.
REQ-025 rx_er=1 in IDLE or PREAMBLE with rx_dv=1 -> DISCARD, err_cnt+1.
REQ-026 Both counters saturate at 16'hFFFF; byte counter 11 bits, cleared on entry to DATA.
REQ-027 Back-to-back frames with minimum 1-cycle rx_dv gap: tail of frame K emitted at the same edge the FSM returns to IDLE, so the next frame's preamble is accepted without loss.

Reset
REQ-028 Asynchronous assert: state IDLE, hold register and flags cleared, o_data_wr=0, ov_data=0, both counters 0, ov_rx_state=0.
REQ-029 Reset mid-frame discards the partial frame; after deassertion no output until a new preamble/SFD; a frame already in progress (rx_dv high at deassertion) is treated per REQ-013 on its current byte.

Structure
REQ-030 Shared package holds state encodings (IDLE/PREAMBLE/DATA/DISCARD), PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, and the default MAX_LEN.
REQ-031 Single flat module; no sub-module (FSM, hold register and counters are tightly coupled).

Verification
REQ-032 7x0x55, 0xD5, data 0x01..0x40 (64 bytes), dv low -> 64 writes, first 9'h101, bytes 2..63 with [8]=0, last 9'h140, frame_cnt=1.
REQ-033 Preamble + SFD + single byte 0xAA, dv low -> no o_data_wr, err_cnt=1, state back to IDLE.
REQ-034 64-byte frame, rx_er asserted on byte 20 -> 19 writes, 19th has [8]=1 (value 9'h113), err_cnt=1, no further writes until dv low then new frame.
REQ-035 MAX_LEN=64, 70-byte frame -> exactly 64 writes, 64th tagged [8]=1, err_cnt=1, frame_cnt=0.
REQ-036 Two 64-byte frames separated by 1 idle cycle -> 128 writes, 4 flagged bytes, frame_cnt=2; first frame then i_rst_n pulsed mid-second frame -> output stops within 1 cycle, counters 0.

Source files
------------

// File: rtl/gmii_rx_tag_pkg.sv
// -----------------------------------------------------------------------------
// gmii_rx_tag_pkg
// Shared definitions for the GMII receive tagger: FSM state encoding, the
// preamble / start-of-frame-delimiter byte values, the default frame length
// limit and a saturating counter helper.
// -----------------------------------------------------------------------------
package gmii_rx_tag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DISCARD  = 2'd3
    } rx_state_e;

    localparam logic [7:0] PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0] SFD_BYTE        = 8'hD5;
    localparam int         MAX_LEN_DEFAULT = 1522;
    localparam int         BYTE_CNT_W      = 11;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/gmii_rx_tag.sv
// -----------------------------------------------------------------------------
// gmii_rx_tag
// Strips preamble/SFD from a GMII receive stream and forwards the frame bytes
// to the byte-to-134-bit splice stage, marking the first and last byte of
// each delivered frame with a boundary flag. Each byte is held for one GMII
// cycle so the tail can be tagged once rx_dv falls. Truncated, oversize and
// malformed frames are counted.
//
// Ports
//   i_clk          125 MHz GMII receive clock
//   i_rst_n        asynchronous active-low reset
//   i_gmii_rx_dv   GMII receive data valid
//   i_gmii_rx_er   GMII receive error
//   iv_gmii_rxd    GMII receive byte
//   o_data_wr      write strobe, one per forwarded byte
//   ov_data        [8] boundary flag, [7:0] data byte (zero when no write)
//   ov_frame_cnt   frames delivered with a tagged tail (saturating)
//   ov_err_cnt     frames truncated or dropped (saturating)
//   ov_rx_state    current FSM state (debug)
//
// State      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | waiting for rx_dv with a preamble or SFD byte
// PREAMBLE   | inside the 0x55 preamble run, waiting for the SFD
// DATA       | frame bytes flow through the one-byte hold register
// DISCARD    | bad/aborted frame, ignore bytes until rx_dv drops
// -----------------------------------------------------------------------------
module gmii_rx_tag
    import gmii_rx_tag_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_gmii_rx_dv,
    input  logic        i_gmii_rx_er,
    input  logic [7:0]  iv_gmii_rxd,
    output logic        o_data_wr,
    output logic [8:0]  ov_data,
    output logic [15:0] ov_frame_cnt,
    output logic [15:0] ov_err_cnt,
    output logic [1:0]  ov_rx_state
);

    localparam logic [BYTE_CNT_W-1:0] MAX_LEN_C = MAX_LEN[BYTE_CNT_W-1:0];

    rx_state_e             state_q, state_d;
    logic [7:0]            hold_q, hold_d;
    logic                  hold_vld_q, hold_vld_d;
    logic                  head_done_q, head_done_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic                  wr_q, wr_d;
    logic [8:0]            data_q, data_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic [15:0]           err_cnt_q, err_cnt_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= 8'h00;
            hold_vld_q  <= 1'b0;
            head_done_q <= 1'b0;
            byte_cnt_q  <= '0;
            wr_q        <= 1'b0;
            data_q      <= 9'h000;
            frame_cnt_q <= 16'h0000;
            err_cnt_q   <= 16'h0000;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            head_done_q <= head_done_d;
            byte_cnt_q  <= byte_cnt_d;
            wr_q        <= wr_d;
            data_q      <= data_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        head_done_d = head_done_q;
        byte_cnt_d  = byte_cnt_q;
        wr_d        = 1'b0;
        data_d      = 9'h000;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            // IDLE and PREAMBLE react identically to a valid byte; only
            // rx_dv low differs (PREAMBLE falls back to IDLE silently).
            ST_IDLE, ST_PREAMBLE: begin
                if (!i_gmii_rx_dv) begin
                    state_d = ST_IDLE;
                end else if (i_gmii_rx_er) begin
                    state_d   = ST_DISCARD;
                    err_cnt_d = sat_inc16(err_cnt_q);
                end else if (iv_gmii_rxd == PREAMBLE_BYTE) begin
                    state_d = ST_PREAMBLE;
                end else if (iv_gmii_rxd == SFD_BYTE) begin
                    state_d     = ST_DATA;
                    hold_vld_d  = 1'b0;
                    head_done_d = 1'b0;
                    byte_cnt_d  = '0;
                end else begin
                    state_d   = ST_DISCARD;
                    err_cnt_d = sat_inc16(err_cnt_q);
                end
            end

            ST_DATA: begin
                if (!i_gmii_rx_dv) begin
                    // A tail is only legal once a distinct head went out,
                    // i.e. the frame carried at least two bytes.
                    state_d    = ST_IDLE;
                    hold_vld_d = 1'b0;
                    if (hold_vld_q && head_done_q) begin
                        wr_d        = 1'b1;
                        data_d      = {1'b1, hold_q};
                        frame_cnt_d = sat_inc16(frame_cnt_q);
                    end else begin
                        err_cnt_d = sat_inc16(err_cnt_q);
                    end
                end else if (i_gmii_rx_er) begin
                    // Close the frame downstream if it was already opened,
                    // otherwise nothing has left yet and the byte is dropped.
                    state_d    = ST_DISCARD;
                    hold_vld_d = 1'b0;
                    err_cnt_d  = sat_inc16(err_cnt_q);
                    if (hold_vld_q && head_done_q) begin
                        wr_d   = 1'b1;
                        data_d = {1'b1, hold_q};
                    end
                end else if (byte_cnt_q == MAX_LEN_C) begin
                    // Limit reached and yet another byte: truncate here.
                    state_d    = ST_DISCARD;
                    hold_vld_d = 1'b0;
                    err_cnt_d  = sat_inc16(err_cnt_q);
                    wr_d       = hold_vld_q;
                    data_d     = hold_vld_q ? {1'b1, hold_q} : 9'h000;
                end else begin
                    if (hold_vld_q) begin
                        wr_d        = 1'b1;
                        data_d      = {~head_done_q, hold_q};
                        head_done_d = 1'b1;
                    end
                    hold_d     = iv_gmii_rxd;
                    hold_vld_d = 1'b1;
                    byte_cnt_d = byte_cnt_q + {{(BYTE_CNT_W-1){1'b0}}, 1'b1};
                end
            end

            ST_DISCARD: begin
                if (!i_gmii_rx_dv) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_data_wr    = wr_q;
    assign ov_data      = data_q;
    assign ov_frame_cnt = frame_cnt_q;
    assign ov_err_cnt   = err_cnt_q;
    assign ov_rx_state  = state_q;

endmodule

// File: tb/tb_gmii_rx_tag.sv
module tb_gmii_rx_tag;
    import gmii_rx_tag_pkg::*;

    localparam int ML = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dv, er;
    logic [7:0]  rxd;
    logic        data_wr;
    logic [8:0]  data;
    logic [15:0] frame_cnt, err_cnt;
    logic [1:0]  rx_state;

    always #5 clk = ~clk;

    gmii_rx_tag #(.MAX_LEN(ML)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_gmii_rx_dv (dv),
        .i_gmii_rx_er (er),
        .iv_gmii_rxd  (rxd),
        .o_data_wr    (data_wr),
        .ov_data      (data),
        .ov_frame_cnt (frame_cnt),
        .ov_err_cnt   (err_cnt),
        .ov_rx_state  (rx_state)
    );

    typedef struct {
        logic [8:0] word;
        int         cyc;
    } exp_t;

    exp_t       sbq[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         wr_seen = 0;
    int         flag_seen = 0;
    logic [8:0] last_word = 9'h000;
    int         exp_frames = 0;
    int         exp_errs = 0;
    logic [7:0] fdata [0:127];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest expected word at the
    // expected cycle; idle cycles must present an all-zero data bus.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            checks++;
            if (data_wr === 1'b1) begin
                wr_seen++;
                last_word = data;
                if (data[8]) flag_seen++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write got=%h cyc=%0d", data, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (data !== e.word || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL data_word got=%h@%0d exp=%h@%0d",
                                 data, cyc, e.word, e.cyc);
                    end
                end
            end else if (data !== 9'h000 || data_wr !== 1'b0) begin
                failures++;
                $display("FAIL idle_bus got_wr=%b got_data=%h exp=0/000", data_wr, data);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic chk_counters(input string tag);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
        chk({tag, "_err_cnt"},   32'(err_cnt),   32'(exp_errs));
    endtask

    task automatic settle();
        dv = 1'b0; er = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Drive one frame: npre preamble bytes, SFD (or a bad byte), ndata bytes
    // from fdata, optional rx_er on the SFD or on data byte er_at (1-based),
    // followed by gap idle cycles. Expectations come from the frame rules.
    task automatic run_frame(input int npre, input bit bad_sfd, input bit er_pre,
                             input int ndata, input int er_at, input int gap);
        int  total;
        int  n;
        bit  emit;
        int  c0;
        logic [7:0] bad;
        total = npre + 1 + ndata;
        @(posedge clk); #1;
        c0 = cyc;
        chk("frame_start_state", 32'(rx_state), 32'(ST_IDLE));
        chk_counters("frame_start");

        if (bad_sfd || er_pre) begin
            n = 0; emit = 1'b0; exp_errs = sat(exp_errs);
        end else if (er_at > 0) begin
            n = er_at - 1; emit = (n >= 2); exp_errs = sat(exp_errs);
        end else if (ndata > ML) begin
            n = ML; emit = 1'b1; exp_errs = sat(exp_errs);
        end else begin
            n = ndata; emit = (n >= 2);
            if (emit) exp_frames = sat(exp_frames);
            else      exp_errs   = sat(exp_errs);
        end
        if (emit) begin
            for (int i = 1; i <= n; i++) begin
                exp_t e;
                e.word = {(i == 1 || i == n), fdata[i-1]};
                e.cyc  = c0 + npre + i + 2;
                sbq.push_back(e);
            end
        end

        do bad = 8'($urandom); while (bad == PREAMBLE_BYTE || bad == SFD_BYTE);
        for (int j = 0; j < total; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            dv = 1'b1;
            er = 1'b0;
            if (j < npre) begin
                rxd = PREAMBLE_BYTE;
            end else if (j == npre) begin
                rxd = bad_sfd ? bad : SFD_BYTE;
                er  = er_pre;
            end else begin
                rxd = fdata[j-npre-1];
                er  = ((j - npre) == er_at);
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            dv = 1'b0; er = 1'b0; rxd = 8'($urandom);
        end
    endtask

    initial begin
        int w0, f0, m, c0, lim;
        rst_n = 1'b0; dv = 1'b0; er = 1'b0; rxd = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr",    32'(data_wr),   32'h0);
        chk("rst_data",  32'(data),      32'h0);
        chk("rst_frame", 32'(frame_cnt), 32'h0);
        chk("rst_err",   32'(err_cnt),   32'h0);
        chk("rst_state", 32'(rx_state),  32'h0);
        #2 rst_n = 1'b1;

        // 64-byte frame 0x01..0x40 after full preamble
        for (int i = 0; i < 128; i++) fdata[i] = 8'(i + 1);
        w0 = wr_seen; f0 = flag_seen;
        run_frame(7, 0, 0, 64, 0, 1);
        settle();
        chk("f64_writes", 32'(wr_seen - w0), 32'd64);
        chk("f64_flags",  32'(flag_seen - f0), 32'd2);
        chk("f64_last",   32'(last_word), 32'h140);
        chk_counters("f64");

        // single data byte: dropped, counted as error
        fdata[0] = 8'hAA;
        w0 = wr_seen;
        run_frame(7, 0, 0, 1, 0, 1);
        settle();
        chk("one_writes", 32'(wr_seen - w0), 32'd0);
        chk("one_state",  32'(rx_state), 32'(ST_IDLE));
        chk("one_err",    32'(err_cnt), 32'd1);

        // rx_er on byte 20 of a 64-byte frame
        for (int i = 0; i < 128; i++) fdata[i] = 8'(i + 1);
        w0 = wr_seen;
        run_frame(7, 0, 0, 64, 20, 1);
        settle();
        chk("er20_writes", 32'(wr_seen - w0), 32'd19);
        chk("er20_last",   32'(last_word), 32'h113);
        chk_counters("er20");

        // oversize 70-byte frame against a 64-byte limit
        w0 = wr_seen;
        run_frame(7, 0, 0, 70, 0, 1);
        settle();
        chk("big_writes", 32'(wr_seen - w0), 32'd64);
        chk("big_last",   32'(last_word), 32'h140);
        chk_counters("big");

        // two frames with a single idle cycle between them
        w0 = wr_seen; f0 = flag_seen;
        run_frame(7, 0, 0, 64, 0, 1);
        run_frame(7, 0, 0, 64, 0, 1);
        settle();
        chk("b2b_writes", 32'(wr_seen - w0), 32'd128);
        chk("b2b_flags",  32'(flag_seen - f0), 32'd4);
        chk_counters("b2b");

        // randomized frames
        for (int k = 0; k < 40; k++) begin
            int npre, r, nd, ea, hi;
            bit bsfd, erp;
            for (int i = 0; i < 128; i++) fdata[i] = 8'($urandom);
            npre = int'($urandom_range(0, 7));
            r    = int'($urandom_range(0, 9));
            bsfd = (r == 0);
            erp  = (r == 1);
            r    = int'($urandom_range(0, 9));
            if (r == 0)      nd = int'($urandom_range(0, 1));
            else if (r == 1) nd = int'($urandom_range(ML + 1, 80));
            else             nd = int'($urandom_range(2, ML));
            hi = (nd < ML + 1) ? nd : ML + 1;
            ea = (nd > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, hi)) : 0;
            run_frame(npre, bsfd, erp, nd, ea, int'($urandom_range(1, 3)));
        end
        settle();
        lim = 0;
        while (sbq.size() != 0 && lim < 20) begin @(posedge clk); lim++; end
        #1;
        chk("rand_drain", 32'(sbq.size()), 32'd0);
        chk_counters("rand");

        // reset pulse in the middle of a frame
        for (int i = 0; i < 128; i++) fdata[i] = 8'($urandom);
        m = 10;
        @(posedge clk); #1;
        c0 = cyc;
        for (int i = 1; i < m; i++) begin
            exp_t e;
            e.word = {(i == 1), fdata[i-1]};
            e.cyc  = c0 + 7 + i + 2;
            sbq.push_back(e);
        end
        for (int j = 0; j <= 7 + m; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            dv = 1'b1; er = 1'b0;
            rxd = (j < 7) ? PREAMBLE_BYTE : (j == 7) ? SFD_BYTE : fdata[j-8];
        end
        @(posedge clk); #1;
        rxd = 8'h77;
        #6 rst_n = 1'b0;
        #1;
        exp_frames = 0; exp_errs = 0;
        chk("rstmid_wr",    32'(data_wr),  32'h0);
        chk("rstmid_data",  32'(data),     32'h0);
        chk("rstmid_state", 32'(rx_state), 32'h0);
        chk("rstmid_queue", 32'(sbq.size()), 32'd0);
        chk_counters("rstmid");
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_errs = 1;
        chk("rstrel_state", 32'(rx_state), 32'(ST_DISCARD));
        chk_counters("rstrel");
        dv = 1'b0;
        @(posedge clk); #1;
        chk("rstrel_idle", 32'(rx_state), 32'(ST_IDLE));

        // clean frame afterwards
        w0 = wr_seen;
        run_frame(3, 0, 0, 10, 0, 3);
        settle();
        chk("post_writes", 32'(wr_seen - w0), 32'd10);
        chk("post_queue",  32'(sbq.size()), 32'd0);
        chk_counters("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
